// File: rtl/dm_cache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through cache controller.
package dm_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int idx_width(input int lines);
        return clog2(lines);
    endfunction

    function automatic int tag_width(input int a_width, input int lines);
        return a_width - clog2(lines);
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// Request/response bus used on both sides of the cache: CPU-facing (cache is slave)
// and RAM-facing (cache is master, where ready carries the memory acknowledge).
interface dm_cache_ctrl_if #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 8
);
    logic               req;
    logic               we;
    logic [A_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0] wdata;
    logic [D_WIDTH-1:0] rdata;
    logic               ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/cache_line_array.sv
// Line storage: LINES entries of {valid, tag, data}, combinational read by index,
// one synchronous write port and a synchronous invalidate-all.
module cache_line_array #(
    parameter int D_WIDTH = 8,
    parameter int TAG_W   = 6,
    parameter int LINES   = 4,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               inval_all,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [D_WIDTH-1:0] rd_data,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [D_WIDTH-1:0] wr_data
);
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags [LINES];
    logic [D_WIDTH-1:0] data [LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

    always_ff @(posedge clk) begin
        if (clr || inval_all) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data storage has no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-through cache controller: read hits served locally, read misses
// filled from RAM, every write forwarded to RAM (updating the line only on a hit).
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int D_WIDTH   = 8,
    parameter int A_WIDTH   = 8,
    parameter int LINES     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 flush,
    dm_cache_ctrl_if.slave       cpu,
    dm_cache_ctrl_if.master      mem,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    localparam int IDX_W = idx_width(LINES);
    localparam int TAG_W = tag_width(A_WIDTH, LINES);

    state_t             state;
    logic               cpu_ready_r;
    logic               mem_req_r;
    logic               mem_we_r;
    logic [D_WIDTH-1:0] cpu_rdata_r;
    logic [D_WIDTH-1:0] mem_wdata_r;
    logic [A_WIDTH-1:0] mem_addr_r;

    logic [IDX_W-1:0]   cpu_idx;
    logic [TAG_W-1:0]   cpu_tag;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [D_WIDTH-1:0] line_data;
    logic               hit;
    logic               accept;
    logic               fill_done;
    logic               inval_all;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [TAG_W-1:0]   wr_tag;
    logic [D_WIDTH-1:0] wr_data;

    assign cpu_idx = cpu.addr[IDX_W-1:0];
    assign cpu_tag = cpu.addr[A_WIDTH-1:IDX_W];
    assign hit     = line_valid && (line_tag == cpu_tag);

    // The held request is not re-accepted during its own ready cycle; flush wins over a request.
    assign accept    = (state == ST_IDLE) && !flush && cpu.req && !cpu_ready_r;
    assign fill_done = (state == ST_FILL) && mem.ready;
    assign inval_all = (state == ST_IDLE) && flush;

    // A fill takes its index/tag from the registered miss address, a write hit from the live request.
    assign wr_en   = fill_done || (accept && cpu.we && hit);
    assign wr_idx  = fill_done ? mem_addr_r[IDX_W-1:0] : cpu_idx;
    assign wr_tag  = fill_done ? mem_addr_r[A_WIDTH-1:IDX_W] : cpu_tag;
    assign wr_data = fill_done ? mem.rdata : cpu.wdata;

    cache_line_array #(
        .D_WIDTH (D_WIDTH),
        .TAG_W   (TAG_W),
        .LINES   (LINES),
        .IDX_W   (IDX_W)
    ) u_lines (
        .clk       (clk),
        .clr       (clr),
        .inval_all (inval_all),
        .rd_idx    (cpu_idx),
        .rd_valid  (line_valid),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_tag    (wr_tag),
        .wr_data   (wr_data)
    );

    // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= ST_IDLE;
            cpu_ready_r <= 1'b0;
            cpu_rdata_r <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            cpu_ready_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (cpu.we) begin
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= cpu.addr;
                            mem_wdata_r <= cpu.wdata;
                            state       <= ST_WRITE;
                        end else if (hit) begin
                            cpu_rdata_r <= line_data;
                            cpu_ready_r <= 1'b1;
                            if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
                        end else begin
                            mem_req_r  <= 1'b1;
                            mem_we_r   <= 1'b0;
                            mem_addr_r <= cpu.addr;
                            if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
                            state      <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (mem.ready) begin
                        cpu_rdata_r <= mem.rdata;
                        cpu_ready_r <= 1'b1;
                        mem_req_r   <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (mem.ready) begin
                        cpu_ready_r <= 1'b1;
                        mem_req_r   <= 1'b0;
                        mem_we_r    <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cpu.rdata = cpu_rdata_r;
    assign cpu.ready = cpu_ready_r;
    assign mem.req   = mem_req_r;
    assign mem.we    = mem_we_r;
    assign mem.addr  = mem_addr_r;
    assign mem.wdata = mem_wdata_r;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: a line-presence model plus a reference memory
// predict every CPU response and RAM request; monitors compare as the DUT produces them.
module tb_dm_cache_ctrl;
    localparam int D_WIDTH   = 8;
    localparam int A_WIDTH   = 8;
    localparam int LINES     = 4;
    localparam int CNT_WIDTH = 2;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    typedef struct {
        bit         we;
        logic [7:0] rdata;
        int         hits;
        int         misses;
        int         lat;
        int         issue_cyc;
    } cpu_exp_t;

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } mem_exp_t;

    logic                 clk = 1'b0;
    logic                 clr = 1'b1;
    logic                 flush = 1'b0;
    logic [CNT_WIDTH-1:0] hit_count;
    logic [CNT_WIDTH-1:0] miss_count;

    dm_cache_ctrl_if #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) cpu_bus ();
    dm_cache_ctrl_if #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) mem_bus ();

    dm_cache_ctrl #(
        .D_WIDTH   (D_WIDTH),
        .A_WIDTH   (A_WIDTH),
        .LINES     (LINES),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .flush      (flush),
        .cpu        (cpu_bus),
        .mem        (mem_bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    cpu_exp_t   cpu_q[$];
    mem_exp_t   mem_q[$];
    logic [7:0] ram[256];
    logic [7:0] ref_mem[256];
    bit         mdl_valid[LINES];
    int         mdl_tag[LINES];
    int         mdl_hits;
    int         mdl_misses;
    int         n_checks;
    int         n_fail;
    int         cyc;
    int         ack_delay;
    int         rst_epoch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: data always equals memory (write-through); the cache only decides hit or miss.
    task automatic predict(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                           input bit fl, input int delay, output cpu_exp_t e);
        mem_exp_t m;
        int idx;
        int tag;
        bit hit;
        idx = int'(addr) % LINES;
        tag = int'(addr) / LINES;
        if (fl) foreach (mdl_valid[i]) mdl_valid[i] = 1'b0;
        hit = mdl_valid[idx] && (mdl_tag[idx] == tag);
        e.we = we;
        e.rdata = ref_mem[addr];
        e.issue_cyc = cyc;
        if (we) begin
            ref_mem[addr] = wdata;
            m.we = 1'b1; m.addr = addr; m.wdata = wdata;
            mem_q.push_back(m);
            e.lat = 3 + delay;
        end else if (hit) begin
            if (mdl_hits < CNT_MAX) mdl_hits++;
            e.lat = 1;
        end else begin
            if (mdl_misses < CNT_MAX) mdl_misses++;
            mdl_valid[idx] = 1'b1;
            mdl_tag[idx] = tag;
            m.we = 1'b0; m.addr = addr; m.wdata = 8'h00;
            mem_q.push_back(m);
            e.lat = 3 + delay;
        end
        if (fl) e.lat++;
        e.hits = mdl_hits;
        e.misses = mdl_misses;
    endtask

    task automatic issue(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                         input bit fl, input int delay);
        cpu_exp_t e;
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        ack_delay = delay;
        predict(we, addr, wdata, fl, delay, e);
        cpu_q.push_back(e);
        cpu_bus.req = 1'b1;
        cpu_bus.we = we;
        cpu_bus.addr = addr;
        cpu_bus.wdata = wdata;
        flush = fl;
        if (fl) begin
            @(posedge clk); #1;
            flush = 1'b0;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (cpu_bus.ready === 1'b1);
        end
        if (!seen) begin
            check("ready_timeout", 32'd0, 32'd1);
            cpu_q.delete();
        end
        @(posedge clk); #1;
        cpu_bus.req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        clr = 1'b1;
        cpu_bus.req = 1'b0;
        flush = 1'b0;
        rst_epoch++;
        @(posedge clk); #1;
        clr = 1'b0;
        cpu_q.delete();
        foreach (mdl_valid[i]) mdl_valid[i] = 1'b0;
        mdl_hits = 0;
        mdl_misses = 0;
        @(negedge clk);
        check("rst_cpu_ready", cpu_bus.ready, 0);
        check("rst_mem_req", mem_bus.req, 0);
        check("rst_mem_we", mem_bus.we, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        check("rst_cpu_rdata", cpu_bus.rdata, 0);
        check("rst_mem_addr", mem_bus.addr, 0);
        check("rst_mem_wdata", mem_bus.wdata, 0);
    endtask

    initial forever @(posedge clk) cyc++;

    // CPU-side monitor: every ready pulse must match the oldest outstanding expectation.
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_bus.ready === 1'b1) begin
                if (cpu_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_ready: cpu_ready=1 with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    e = cpu_q.pop_front();
                    if (!e.we) check("cpu_rdata", cpu_bus.rdata, e.rdata);
                    check("hit_count", hit_count, e.hits);
                    check("miss_count", miss_count, e.misses);
                    check("latency", cyc - e.issue_cyc, e.lat);
                end
            end
        end
    end

    // RAM-side monitor: each new mem_req must match the oldest expected memory access.
    initial begin
        mem_exp_t m;
        logic     prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_bus.req === 1'b1 && !prev) begin
                if (mem_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_mem_req: mem_req=1 addr 0x%0h with nothing expected (cycle %0d)",
                             mem_bus.addr, cyc);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_we", mem_bus.we, m.we);
                    check("mem_addr", mem_bus.addr, m.addr);
                    if (m.we) check("mem_wdata", mem_bus.wdata, m.wdata);
                end
            end
            prev = (mem_bus.req === 1'b1);
        end
    end

    // RAM responder: acks ack_delay+1 cycles after seeing a request; a late ack survives a reset.
    initial begin
        logic [7:0] a;
        logic [7:0] wd;
        logic       w;
        logic       prev;
        int         d;
        int         ep;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_bus.req === 1'b1 && !prev) begin
                a = mem_bus.addr; w = mem_bus.we; wd = mem_bus.wdata;
                d = ack_delay; ep = rst_epoch;
                repeat (d) @(posedge clk);
                @(posedge clk); #1;
                if (ep == rst_epoch) check("mem_req_held", mem_bus.req, 1);
                mem_bus.ready = 1'b1;
                mem_bus.rdata = ram[a];
                if (w) ram[a] = wd;
                @(posedge clk); #1;
                mem_bus.ready = 1'b0;
                mem_bus.rdata = 8'h00;
                prev = 1'b1;
            end else begin
                prev = (mem_bus.req === 1'b1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cpu_exp_t dropped;
        bit       we;
        bit       fl;
        cpu_bus.req = 1'b0; cpu_bus.we = 1'b0; cpu_bus.addr = '0; cpu_bus.wdata = '0;
        mem_bus.ready = 1'b0; mem_bus.rdata = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[8'h13] = 8'h5A;
        ref_mem[8'h13] = 8'h5A;

        do_reset();

        // Cold miss, then hit, then write hit, then read back the written value.
        issue(1'b0, 8'h13, 8'h00, 1'b0, 0);
        issue(1'b0, 8'h13, 8'h00, 1'b0, 0);
        issue(1'b1, 8'h13, 8'hC3, 1'b0, 0);
        issue(1'b0, 8'h13, 8'h00, 1'b0, 0);

        // Flush together with a read of a valid line: the read misses one cycle later.
        issue(1'b0, 8'h13, 8'h00, 1'b1, 0);

        // Conflicting addresses evict each other.
        do_reset();
        issue(1'b0, 8'h01, 8'h00, 1'b0, 0);
        issue(1'b0, 8'h05, 8'h00, 1'b0, 0);
        issue(1'b0, 8'h01, 8'h00, 1'b0, 0);

        // Reset mid-fill: the late ack is ignored and the line stays invalid.
        do_reset();
        @(posedge clk); #1;
        ack_delay = 6;
        predict(1'b0, 8'h22, 8'h00, 1'b0, 6, dropped);
        cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 8'h22;
        repeat (3) @(posedge clk);
        do_reset();
        repeat (12) @(posedge clk);
        issue(1'b0, 8'h22, 8'h00, 1'b0, 1);

        // Hit counter saturation.
        do_reset();
        issue(1'b0, 8'h13, 8'h00, 1'b0, 0);
        for (int i = 0; i < 5; i++) issue(1'b0, 8'h13, 8'h00, 1'b0, 0);
        check("hit_saturated", hit_count, CNT_MAX);

        // Randomized traffic over a small address range so hits, conflicts and flushes all occur.
        for (int n = 0; n < 300; n++) begin
            if (n % 60 == 0) do_reset();
            we = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            issue(we, 8'($urandom_range(0, 15)), 8'($urandom), fl, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (10) @(posedge clk);
        check("cpu_q_drained", cpu_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
